// File: rtl/prime_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : prime_uart_tx
// Description : Accepts one W-bit unsigned value per valid/ready handshake.
//               It converts the value to BCD with a sequential double-dabble
//               (one iteration per clock). It then sends the decimal digits
//               followed by CR LF as back-to-back 8N1 UART frames.
//               Optional macro PRIME_UART_ZSUPP_EN: when defined, leading
//               zero digits are skipped; the least significant digit is
//               always sent.
// Revision    : 1.0 - initial release
// ============================================================================
module prime_uart_tx #(
    parameter int CLK_HZ = 12000000,
    parameter int BAUD   = 115200,
    parameter int W      = 16,
    parameter int NDIG   = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         tx
);

    localparam int c_DIV  = CLK_HZ / BAUD;
    localparam int c_BW   = $clog2(c_DIV);
    localparam int c_CW   = $clog2(W);
    localparam int c_IW   = $clog2(NDIG + 2);
    localparam int c_BCDW = 4 * NDIG;

    localparam logic [c_BW-1:0] c_BAUD_MAX = c_BW'(c_DIV - 1);
    localparam logic [c_CW-1:0] c_ITER_MAX = c_CW'(W - 1);
    localparam logic [c_IW-1:0] c_IDX_CR   = c_IW'(NDIG);
    localparam logic [c_IW-1:0] c_IDX_LF   = c_IW'(NDIG + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_LOAD = 2'd2,
        S_SEND = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [W-1:0]      r_val;
    logic [c_BCDW-1:0] r_bcd;
    logic [c_CW-1:0]   r_iter;
    logic [c_BW-1:0]   r_baud;
    logic [3:0]        r_bit;
    logic [c_IW-1:0]   r_idx;
    logic              r_last;
    logic [9:0]        r_frame;
    logic              r_ready;

    logic              w_accept;
    logic              w_conv_done;
    logic              w_baud_wrap;
    logic              w_frame_done;
    logic [c_BCDW-1:0] w_bcd_adj;
    logic [c_IW-1:0]   w_lead;
    logic [c_IW-1:0]   w_sel;
    logic [3:0]        w_nib;
    logic [7:0]        w_char;

    // r_ready is only ever high while idle, so it alone qualifies acceptance
    assign w_accept     = in_valid && r_ready;
    assign w_conv_done  = (r_state == S_CONV) && (r_iter == c_ITER_MAX);
    assign w_baud_wrap  = (r_baud == c_BAUD_MAX);
    assign w_frame_done = (r_state == S_SEND) && w_baud_wrap && (r_bit == 4'd9);

    assign in_ready = r_ready;
    // Frame register idles at all ones, so its LSB is the line level directly
    assign tx       = r_frame[0];

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift
    always_comb begin
        w_bcd_adj = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end else begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4];
            end
        end
    end

`ifdef PRIME_UART_ZSUPP_EN
    logic w_seen;

    // Count leading zero digits, never skipping the least significant one
    always_comb begin
        w_lead = '0;
        w_seen = 1'b0;
        for (int i = 0; i < NDIG - 1; i++) begin
            if (!w_seen && (r_bcd[4*(NDIG-1-i) +: 4] == 4'd0)) begin
                w_lead = c_IW'(i + 1);
            end else begin
                w_seen = 1'b1;
            end
        end
    end
`else
    assign w_lead = '0;
`endif

    // Character select: the first LOAD after conversion starts past any skipped digits
    always_comb begin
        w_sel  = (r_idx == '0) ? w_lead : r_idx;
        w_nib  = 4'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (w_sel == c_IW'(NDIG - 1 - i)) begin
                w_nib = r_bcd[4*i +: 4];
            end
        end
        if (w_sel < c_IDX_CR) begin
            w_char = 8'h30 + {4'h0, w_nib};
        end else if (w_sel == c_IDX_CR) begin
            w_char = 8'h0D;
        end else begin
            w_char = 8'h0A;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept)    w_state_next = S_CONV;
            S_CONV: if (w_conv_done) w_state_next = S_LOAD;
            S_LOAD: w_state_next = S_SEND;
            S_SEND: if (w_frame_done) w_state_next = r_last ? S_IDLE : S_LOAD;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: capture, conversion, frame load and bit shifting
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_val   <= '0;
            r_bcd   <= '0;
            r_iter  <= '0;
            r_baud  <= '0;
            r_bit   <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
            r_frame <= '1;
            r_ready <= 1'b0;
        end else begin
            r_ready <= (w_state_next == S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_val  <= in_data;
                        r_bcd  <= '0;
                        r_iter <= '0;
                        r_idx  <= '0;
                    end
                end
                S_CONV: begin
                    r_bcd  <= {w_bcd_adj[c_BCDW-2:0], r_val[W-1]};
                    r_val  <= {r_val[W-2:0], 1'b0};
                    r_iter <= r_iter + 1'b1;
                end
                S_LOAD: begin
                    r_frame <= {1'b1, w_char, 1'b0};
                    r_idx   <= w_sel + 1'b1;
                    r_last  <= (w_sel == c_IDX_LF);
                    r_baud  <= '0;
                    r_bit   <= '0;
                end
                S_SEND: begin
                    if (w_baud_wrap) begin
                        r_baud  <= '0;
                        r_frame <= {1'b1, r_frame[9:1]};
                        r_bit   <= (r_bit == 4'd9) ? 4'd0 : r_bit + 1'b1;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prime_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_prime_uart_tx
// Description : Self-checking bench for prime_uart_tx. A UART receiver model
//               decodes tx; expected text is formed from the decimal string
//               of each value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prime_uart_tx;

    localparam int CLK_HZ = 12000000;
    localparam int BAUD   = 115200;
    localparam int W      = 16;
    localparam int NDIG   = 5;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int LIM    = 30000;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data  = '0;
    wire          in_ready;
    wire          tx;

    prime_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .W(W), .NDIG(NDIG)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .tx       (tx)
    );

    always #5 clk = ~clk;

    int          checks    = 0;
    int          errors    = 0;
    longint      cyc       = 0;
    int          acc_cnt   = 0;
    int          rst_epoch = 0;
    longint      acc_cyc   = 0;
    logic [7:0]  q_rx[$];
    longint      q_st[$];
    logic [7:0]  exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected line text for one value, from its decimal string
    function automatic void model(input int unsigned v);
        string s;
        s = $sformatf("%0d", v);
`ifndef PRIME_UART_ZSUPP_EN
        while (s.len() < NDIG) s = {"0", s};
`endif
        for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    // UART receiver: mid-bit sampling; frames cut by a reset are dropped
    initial begin : mon
        logic [7:0] ch;
        logic       sb;
        longint     st;
        int         ep;
        forever begin
            @(posedge clk); #1;
            if (rst_n === 1'b1 && tx === 1'b0) begin
                st = cyc;
                ep = rst_epoch;
                repeat (DIV/2) @(posedge clk);
                #1;
                for (int b = 0; b < 8; b++) begin
                    repeat (DIV) @(posedge clk);
                    #1;
                    ch[b] = tx;
                end
                repeat (DIV) @(posedge clk);
                #1;
                sb = tx;
                if (ep == rst_epoch) begin
                    check("stop_bit", {63'd0, sb}, 64'd1);
                    q_rx.push_back(ch);
                    q_st.push_back(st);
                end
            end
        end
    end

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (in_ready !== 1'b1 && n < LIM) begin step(); n++; end
        check(tag, {63'd0, in_ready}, 64'd1);
    endtask

    task automatic wait_acc(input int target, input string tag);
        int n = 0;
        while (acc_cnt < target && n < LIM) begin step(); n++; end
        check(tag, acc_cnt, target);
    endtask

    task automatic compare_rx(input string tag);
        check({tag, "_len"}, q_rx.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < q_rx.size(); i++)
            check($sformatf("%s_ch%0d", tag, i), q_rx[i], exp_q[i]);
    endtask

    task automatic clear_q;
        q_rx.delete(); q_st.delete(); exp_q.delete();
    endtask

    // One value end to end: latency, busy time, text and frame spacing
    task automatic run_value(input int unsigned v, input string tag);
        int low = 0;
        int k;
        clear_q();
        model(v);
        k = exp_q.size();
        wait_ready({tag, "_rdy"});
        in_valid = 1'b1;
        in_data  = W'(v);
        step();
        acc_cyc  = cyc;
        in_valid = 1'b0;
        while (in_ready === 1'b0 && low < LIM) begin low++; step(); end
        check({tag, "_busy"}, low, W + k * (1 + 10 * DIV));
        compare_rx(tag);
        if (q_st.size() > 0) check({tag, "_lat"}, q_st[0] - acc_cyc, W + 1);
        for (int i = 1; i < q_st.size(); i++)
            check({tag, "_gap"}, q_st[i] - q_st[i-1], 10 * DIV + 1);
    endtask

    initial begin : main
        int base;
        int lowcnt;
        int unsigned primes[3];
        primes[0] = 2; primes[1] = 3; primes[2] = 5;

        // Reset state
        repeat (3) step();
        check("rst_tx", {63'd0, tx}, 64'd1);
        check("rst_rdy", {63'd0, in_ready}, 64'd0);
        rst_n = 1'b1;
        step();
        check("rdy_after_rst", {63'd0, in_ready}, 64'd1);

        run_value(0, "v0");
        run_value(65535, "vmax");
        run_value(7, "v7");
        run_value($urandom_range(0, 65535), "vrnd");

        // Reset during data bits of the second character of 13
        clear_q();
        model(13);
        wait_ready("r13_rdy");
        in_valid = 1'b1; in_data = W'(13);
        step();
        in_valid = 1'b0;
        begin
            int n = 0;
            while (q_rx.size() < 1 && n < LIM) begin step(); n++; end
        end
        check("r13_first_len", q_rx.size(), 1);
        if (q_rx.size() > 0) check("r13_first_ch", q_rx[0], exp_q[0]);
        repeat (DIV/2 + 1 + DIV + 3 * DIV) step();
        rst_n = 1'b0;
        rst_epoch++;
        step();
        check("r13_tx", {63'd0, tx}, 64'd1);
        check("r13_rdy0", {63'd0, in_ready}, 64'd0);
        rst_n = 1'b1;
        step();
        check("r13_rdy1", {63'd0, in_ready}, 64'd1);
        lowcnt = 0;
        repeat (20 * DIV) begin step(); if (tx !== 1'b1) lowcnt++; end
        check("r13_quiet", lowcnt, 0);
        check("r13_nrx", q_rx.size(), 1);

        // Valid held high, data changed mid-transmission
        clear_q();
        model(2);
        model(3);
        base = acc_cnt;
        in_valid = 1'b1; in_data = W'(2);
        wait_acc(base + 1, "hold_acc1");
        repeat (500 + $urandom_range(0, 200)) step();
        in_data = W'(3);
        wait_acc(base + 2, "hold_acc2");
        in_valid = 1'b0;
        wait_ready("hold_done");
        repeat (5) step();
        check("hold_nacc", acc_cnt - base, 2);
        compare_rx("hold");

        // Generator model: present each prime until it is taken
        clear_q();
        base = acc_cnt;
        for (int i = 0; i < 3; i++) begin
            model(primes[i]);
            in_valid = 1'b1;
            in_data  = W'(primes[i]);
            wait_acc(base + i + 1, "gen_acc");
        end
        in_valid = 1'b0;
        wait_ready("gen_done");
        repeat (5) step();
        check("gen_nacc", acc_cnt - base, 3);
        compare_rx("gen");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
